// File: rtl/quic_dec_scan_ctrl.sv
// Frame sequencer for the QUIC decoder: raster/prediction coordinates, per-pixel gating, 2-deep output buffer.
// Optional QUIC_SCAN_PERF_EN adds stall_cnt and frame_cycles performance counters.
module quic_dec_scan_ctrl #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               pix_done,
    input  logic [7:0]         pix_r,
    input  logic [7:0]         pix_g,
    input  logic [7:0]         pix_b,
    output logic               dec_set,
    output logic               dec_en,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] column_pred,
    output logic [COORD_W-1:0] row_pred,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_r,
    output logic [7:0]         out_g,
    output logic [7:0]         out_b,
    output logic               out_sol,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
`ifdef QUIC_SCAN_PERF_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        frame_cycles,
`endif
    output logic               ovf_err
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sol;
        logic       eol;
        logic       eof;
    } entry_t;

    localparam longint unsigned MAX_W = 64'd1 << ADDR_W;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] width_q, height_q, wm1_q, hm1_q;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [COORD_W-1:0] pc_q, pc_d, pr_q, pr_d;
    logic [1:0]         count_q, count_d;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic               cfg_q, cfg_d, ovf_q, ovf_d;
    entry_t             mem_q [2];
    entry_t             head;

    logic geom_bad, width_is_one, push, pop;
    logic at_eol, last_pix, pred_last, pc_eol;

    assign geom_bad     = (width == '0) || (height == '0) || (64'(width) > MAX_W);
    assign width_is_one = (width == COORD_W'(1));

    assign dec_set = (state_q == S_SETUP);
    assign dec_en  = (state_q == S_RUN) && (count_q != 2'd2);
    assign busy    = (state_q == S_SETUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign cfg_err = cfg_q;
    assign ovf_err = ovf_q;

    assign push = pix_done && dec_en;
    assign pop  = out_valid && out_ready;

    assign at_eol    = (col_q == wm1_q);
    assign last_pix  = at_eol && (row_q == hm1_q);
    assign pc_eol    = (pc_q == wm1_q);
    assign pred_last = pc_eol && (pr_q == hm1_q);

    assign column      = col_q;
    assign row         = row_q;
    assign column_pred = pc_q;
    assign row_pred    = pr_q;

    // Head fields read as zero while empty so the buffer storage needs no reset.
    assign head      = mem_q[rd_q];
    assign out_valid = (count_q != 2'd0);
    assign out_r     = out_valid ? head.r   : 8'd0;
    assign out_g     = out_valid ? head.g   : 8'd0;
    assign out_b     = out_valid ? head.b   : 8'd0;
    assign out_sol   = out_valid && head.sol;
    assign out_eol   = out_valid && head.eol;
    assign out_eof   = out_valid && head.eof;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pc_d    = pc_q;
        pr_d    = pr_q;
        cfg_d   = cfg_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d = geom_bad;
                    ovf_d = 1'b0;
                    if (geom_bad) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        col_d   = '0;
                        row_d   = '0;
                        pc_d    = width_is_one ? '0 : COORD_W'(1);
                        pr_d    = width_is_one ? COORD_W'(1) : '0;
                    end
                end
            end
            S_SETUP: state_d = S_RUN;
            S_RUN: begin
                if (pix_done && !dec_en) begin
                    ovf_d = 1'b1;
                end
                if (push) begin
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end else begin
                        col_d = at_eol ? '0 : col_q + COORD_W'(1);
                        row_d = at_eol ? row_q + COORD_W'(1) : row_q;
                        // Prediction stops at the frame's last pixel instead of running past it.
                        if (!pred_last) begin
                            pc_d = pc_eol ? '0 : pc_q + COORD_W'(1);
                            pr_d = pc_eol ? pr_q + COORD_W'(1) : pr_q;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (state_q == S_SETUP) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pc_q    <= '0;
            pr_q    <= '0;
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cfg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pc_q    <= pc_d;
            pr_q    <= pr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cfg_q   <= cfg_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && start) begin
            width_q  <= width;
            height_q <= height;
        end
        if (state_q == S_SETUP) begin
            wm1_q <= width_q - COORD_W'(1);
            hm1_q <= height_q - COORD_W'(1);
        end
        if (push) begin
            mem_q[wr_q] <= '{r: pix_r, g: pix_g, b: pix_b,
                             sol: (col_q == '0), eol: at_eol, eof: last_pix};
        end
    end

`ifdef QUIC_SCAN_PERF_EN
    logic [31:0] stall_q, fcyc_q;

    assign stall_cnt    = stall_q;
    assign frame_cycles = fcyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            fcyc_q  <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
            fcyc_q  <= '0;
        end else begin
            if ((state_q == S_RUN) && !dec_en && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if ((state_q != S_IDLE) && (fcyc_q != '1))            fcyc_q  <= fcyc_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_quic_dec_scan_ctrl.sv
// Randomized bench for quic_dec_scan_ctrl against a frame-level model (pixel index, FIFO queue).
module tb_quic_dec_scan_ctrl;
    localparam int AW = 12;
    localparam int P_IDLE = 0, P_SETUP = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sol;
        logic       eol;
        logic       eof;
    } ent_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, pix_done = 1'b0, out_ready = 1'b0;
    logic [15:0] width = '0, height = '0;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic        dec_set, dec_en, out_valid, out_sol, out_eol, out_eof, busy, done, cfg_err, ovf_err;
    logic [15:0] column, row, column_pred, row_pred;
    logic [7:0]  out_r, out_g, out_b;
`ifdef QUIC_SCAN_PERF_EN
    logic [31:0] stall_cnt, frame_cycles;
`endif

    quic_dec_scan_ctrl #(.COORD_W(16), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
        .pix_done(pix_done), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .dec_set(dec_set), .dec_en(dec_en), .column(column), .row(row),
        .column_pred(column_pred), .row_pred(row_pred), .out_valid(out_valid),
        .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
        .done(done), .cfg_err(cfg_err),
`ifdef QUIC_SCAN_PERF_EN
        .stall_cnt(stall_cnt), .frame_cycles(frame_cycles),
`endif
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          mph = P_IDLE;
    int unsigned mw = 1, mh = 1, mn = 1, mk = 0;
    bit          mcfg = 0, movf = 0;
    logic [15:0] ecol = '0, erow = '0, epc = '0, epr = '0;
    ent_t        mq[$];

    int  pd_pct = 100, rdy_pct = 100, st_pct = 0;
    bit  pd_force = 0, chk_en = 0, dec_set_seen = 0;
    int  done_cnt = 0;
    ent_t        poplog[$];
    logic [15:0] predlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_coords();
        int unsigned p;
        p = (mk + 1 < mn) ? mk + 1 : ((mn > 1) ? mn - 1 : 1);
        ecol = 16'(mk % mw);
        erow = 16'(mk / mw);
        epc  = 16'(p % mw);
        epr  = 16'(p / mw);
    endtask

    task automatic model_step();
        bit   dec, was_empty;
        ent_t e;
        if (reset) begin
            mph = P_IDLE; mq.delete(); mcfg = 0; movf = 0; mk = 0;
            ecol = '0; erow = '0; epc = '0; epr = '0;
            return;
        end
        dec       = (mph == P_RUN) && (mq.size() < 2);
        was_empty = (mq.size() == 0);
        if (!was_empty && out_ready) void'(mq.pop_front());
        case (mph)
            P_IDLE: if (start) begin
                mw = width; mh = height; mcfg = 0; movf = 0;
                if (width == 0 || height == 0 || int'(width) > (1 << AW)) begin
                    mcfg = 1; mph = P_DONE;
                end else begin
                    mn = mw * mh; mk = 0; set_coords(); mph = P_SETUP;
                end
            end
            P_SETUP: begin mq.delete(); mph = P_RUN; end
            P_RUN: if (pix_done) begin
                if (!dec) movf = 1;
                else begin
                    e.r = pix_r; e.g = pix_g; e.b = pix_b;
                    e.sol = (mk % mw) == 0;
                    e.eol = (mk % mw) == mw - 1;
                    e.eof = (mk == mn - 1);
                    mq.push_back(e);
                    if (e.eof) mph = P_DRAIN;
                    else begin mk++; set_coords(); end
                end
            end
            P_DRAIN: if (was_empty) mph = P_DONE;
            P_DONE:  mph = P_IDLE;
            default: mph = P_IDLE;
        endcase
    endtask

    function automatic logic [97:0] dut_vec();
        return {dec_set, dec_en, busy, done, cfg_err, ovf_err, out_valid, out_sol, out_eol, out_eof,
                out_r, out_g, out_b, column, row, column_pred, row_pred};
    endfunction

    function automatic logic [97:0] model_vec();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        return {mph == P_SETUP, (mph == P_RUN) && (mq.size() < 2),
                mph == P_SETUP || mph == P_RUN || mph == P_DRAIN, mph == P_DONE,
                mcfg, movf, mq.size() > 0, h.sol, h.eol, h.eof, h.r, h.g, h.b,
                ecol, erow, epc, epr};
    endfunction

    // Single compare process: log handshakes, advance the model, check all outputs each cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (chk_en) begin
                if (out_valid && out_ready) poplog.push_back({out_r, out_g, out_b, out_sol, out_eol, out_eof});
                if (pix_done && dec_en) predlog.push_back(column_pred);
                if (dec_set) dec_set_seen = 1;
                if (done) done_cnt++;
            end
            model_step();
            if (reset) chk_en = 1;
            #1;
            if (chk_en) begin
                tests++;
                if (dut_vec() !== model_vec()) begin
                    fails++;
                    $display("FAIL outputs t=%0t dut=%h model=%h", $time, dut_vec(), model_vec());
                end
            end
        end
    end

    task automatic tick(input bit st, input bit rs);
        @(negedge clk);
        reset = rs;
        start = st;
        if (!st && ($urandom_range(99) < st_pct)) begin
            start = 1'b1;
            width = 16'($urandom_range(1, 9));
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        pix_done  = (mph == P_RUN) && (pd_force || mq.size() < 2) && ($urandom_range(99) < pd_pct);
        pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (mph != P_IDLE && n < budget) begin tick(0, 0); n++; end
        if (mph != P_IDLE) begin
            tests++; fails++;
            $display("FAIL frame_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic run_frame(input int w, input int h, input int budget);
        width = 16'(w); height = 16'(h);
        tick(1, 0);
        tick(0, 0);
        wait_idle(budget);
    endtask

    initial begin
        bit [2:0]    t1f[4];
        logic [15:0] t1p[4];
        int          n;
        t1f = '{3'b100, 3'b010, 3'b100, 3'b011};
        t1p = '{16'd1, 16'd0, 16'd1, 16'd1};

        tick(0, 1); tick(0, 1); tick(0, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", out_valid, 0);

        // 2x2 frame, free-flowing
        poplog.delete(); predlog.delete(); done_cnt = 0;
        run_frame(2, 2, 100);
        check("t1_outputs", poplog.size(), 4);
        for (int i = 0; i < 4 && i < poplog.size(); i++) check("t1_flags", poplog[i][2:0], t1f[i]);
        for (int i = 0; i < 4 && i < predlog.size(); i++) check("t1_colpred", predlog[i], t1p[i]);
        check("t1_done_pulses", done_cnt, 1);

        // 3x1 frame with the sink stalled early on
        poplog.delete();
        width = 16'd3; height = 16'd1; rdy_pct = 0;
        tick(1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0);
        check("t2_dec_en_low", dec_en, 0);
        check("t2_column_held", column, 2);
        rdy_pct = 100;
        wait_idle(100);
        check("t2_outputs", poplog.size(), 3);
        if (poplog.size() == 3) check("t2_eof_pattern", {poplog[0].eof, poplog[1].eof, poplog[2].eof}, 3'b001);
        check("t2_ovf", ovf_err, 0);

        // zero width
        dec_set_seen = 0; done_cnt = 0;
        width = 16'd0; height = 16'd5;
        tick(1, 0); tick(0, 0);
        check("t3_done", done, 1);
        check("t3_cfg_err", cfg_err, 1);
        wait_idle(10);
        check("t3_no_dec_set", dec_set_seen, 0);
        check("t3_cfg_held", cfg_err, 1);

        // width above line-buffer capacity, then the maximum legal width
        width = 16'd4097; height = 16'd1;
        tick(1, 0); tick(0, 0);
        check("t4_cfg_err", cfg_err, 1);
        wait_idle(10);
        poplog.delete();
        run_frame(4096, 1, 10000);
        check("t4_outputs", poplog.size(), 4096);
        check("t4_cfg_cleared", cfg_err, 0);
        if (poplog.size() > 0) check("t4_last_eof", poplog[poplog.size()-1].eof, 1);

        // overflow while the buffer is full, plus an ignored mid-frame start
        width = 16'd4; height = 16'd2; rdy_pct = 0; pd_force = 1;
        tick(1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0);
        width = 16'd1; height = 16'd1;
        tick(1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0);
        check("t5_ovf", ovf_err, 1);
        check("t5_column_held", column, 2);
        check("t5_busy", busy, 1);
        rdy_pct = 100; pd_force = 0;
        wait_idle(200);
        check("t5_ovf_sticky", ovf_err, 1);

        // reset with one pixel buffered
        width = 16'd4; height = 16'd4; rdy_pct = 0;
        tick(1, 0);
        n = 0;
        while (mq.size() != 1 && n < 10) begin tick(0, 0); n++; end
        check("t6_one_buffered", out_valid, 1);
        tick(0, 1); tick(0, 0);
        check("t6_all_zero", (dut_vec() == '0), 1);
        rdy_pct = 100; poplog.delete();
        run_frame(3, 2, 100);
        check("t6_clean_outputs", poplog.size(), 6);
        check("t6_clean_ovf", ovf_err, 0);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            pd_pct   = $urandom_range(20, 100);
            rdy_pct  = $urandom_range(10, 100);
            pd_force = ($urandom_range(3) == 0);
            st_pct   = 5;
            run_frame(($urandom_range(9) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(1, 4), 3000);
        end
        st_pct = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
